// File: rtl/timer_mode_controller.sv
// Mode/run controller for the two-digit-pair up-counter timer datapath.
// Buttons are synchronised and edge-detected here; end values, run enable and alarm are registered.

module tmc_btn_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchroniser chain plus the delayed copy used for rising-edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{1'b0}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], btn_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign press_o = sync_q[STAGES-1] & ~prev_q;

endmodule

module timer_mode_controller #(
  parameter int unsigned LSB_MAX      = 99,
  parameter int unsigned MSB_MAX      = 99,
  parameter int unsigned ALARM_CYCLES = 200,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       mode_i,
  input  logic       start_btn_i,
  input  logic       clear_btn_i,
  input  logic [7:0] preset_msb_i,
  input  logic [7:0] preset_lsb_i,
  input  logic [7:0] msb_val_i,
  input  logic [7:0] lsb_val_i,
  output logic       start_stop_o,
  output logic       core_rst_n_o,
  output logic [7:0] msb_loadval_o,
  output logic [7:0] lsb_loadval_o,
  output logic [7:0] msb_resetval_o,
  output logic [7:0] lsb_resetval_o,
  output logic [7:0] msb_end_o,
  output logic [7:0] lsb_end_o,
  output logic       lsb_overflow_o,
  output logic       done_o,
  output logic       alarm_o,
  output logic [2:0] state_o
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned ACNT_W = (ALARM_CYCLES < 1) ? 1 : $clog2(ALARM_CYCLES + 1);

  localparam logic [7:0]        LSB_MAX_C = 8'(LSB_MAX);
  localparam logic [7:0]        MSB_MAX_C = 8'(MSB_MAX);
  localparam logic [ACNT_W-1:0] ALARM_C   = ACNT_W'(ALARM_CYCLES);
  localparam logic [ACNT_W-1:0] ACNT_ONE  = ACNT_W'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUNNING = 3'd1;
  localparam logic [2:0] S_PAUSED  = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;

  logic              start_press;
  logic              clear_press;
  logic              at_end;
  logic              end_zero;

  logic [2:0]        state_q, state_d;
  logic              start_stop_q, start_stop_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              done_q, done_d;
  logic              alarm_q, alarm_d;
  logic [ACNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
  logic [7:0]        msb_end_q, msb_end_d;
  logic [7:0]        lsb_end_q, lsb_end_d;

  tmc_btn_sync #(.STAGES(SYNC_N)) u_start_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (start_btn_i),
    .press_o (start_press)
  );

  tmc_btn_sync #(.STAGES(SYNC_N)) u_clear_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (clear_btn_i),
    .press_o (clear_press)
  );

  assign at_end   = (msb_val_i == msb_end_q) && (lsb_val_i == lsb_end_q);
  assign end_zero = (msb_end_q == 8'd0) && (lsb_end_q == 8'd0);

  // End-value selection: tracks mode/preset only while idle, frozen otherwise
  always_comb begin
    msb_end_d = msb_end_q;
    lsb_end_d = lsb_end_q;
    if (state_q == S_IDLE) begin
      if (mode_i) begin
        msb_end_d = preset_msb_i;
        lsb_end_d = (preset_lsb_i > LSB_MAX_C) ? LSB_MAX_C : preset_lsb_i;
      end else begin
        msb_end_d = MSB_MAX_C;
        lsb_end_d = LSB_MAX_C;
      end
    end else begin
      msb_end_d = msb_end_q;
      lsb_end_d = lsb_end_q;
    end
  end

  // Run-state sequencing; clear overrides everything, end detection beats pause
  always_comb begin
    state_d      = state_q;
    start_stop_d = start_stop_q;
    alarm_cnt_d  = alarm_cnt_q;
    if (clear_press) begin
      state_d      = S_IDLE;
      start_stop_d = 1'b0;
      alarm_cnt_d  = {ACNT_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          start_stop_d = 1'b0;
          alarm_cnt_d  = {ACNT_W{1'b0}};
          if (start_press) begin
            if (end_zero) begin
              state_d = S_DONE;
            end else begin
              state_d      = S_RUNNING;
              start_stop_d = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUNNING: begin
          if (at_end) begin
            state_d      = S_DONE;
            start_stop_d = 1'b0;
            alarm_cnt_d  = {ACNT_W{1'b0}};
          end else if (start_press) begin
            state_d      = S_PAUSED;
            start_stop_d = 1'b0;
          end else begin
            state_d      = S_RUNNING;
            start_stop_d = 1'b1;
          end
        end
        S_PAUSED: begin
          if (start_press) begin
            state_d      = S_RUNNING;
            start_stop_d = 1'b1;
          end else begin
            state_d      = S_PAUSED;
            start_stop_d = 1'b0;
          end
        end
        S_DONE: begin
          state_d      = S_DONE;
          start_stop_d = 1'b0;
          // Counts DONE cycles elapsed since entry, saturating at the alarm length
          if (alarm_cnt_q < ALARM_C) begin
            alarm_cnt_d = alarm_cnt_q + ACNT_ONE;
          end else begin
            alarm_cnt_d = alarm_cnt_q;
          end
        end
        default: begin
          state_d      = S_IDLE;
          start_stop_d = 1'b0;
          alarm_cnt_d  = {ACNT_W{1'b0}};
        end
      endcase
    end
  end

  // Derived registered flags
  always_comb begin
    done_d       = (state_d == S_DONE);
    alarm_d      = (state_d == S_DONE) && (alarm_cnt_d < ALARM_C);
    core_rst_n_d = ~clear_press;
  end

  // Controller state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      start_stop_q <= 1'b0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      alarm_q      <= 1'b0;
      alarm_cnt_q  <= {ACNT_W{1'b0}};
      msb_end_q    <= MSB_MAX_C;
      lsb_end_q    <= LSB_MAX_C;
    end else begin
      state_q      <= state_d;
      start_stop_q <= start_stop_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      alarm_q      <= alarm_d;
      alarm_cnt_q  <= alarm_cnt_d;
      msb_end_q    <= msb_end_d;
      lsb_end_q    <= lsb_end_d;
    end
  end

  // Combinational so the LSB reload and MSB increment land on the same edge
  assign lsb_overflow_o = start_stop_q && (lsb_val_i == LSB_MAX_C) && !at_end;

  assign start_stop_o   = start_stop_q;
  assign core_rst_n_o   = core_rst_n_q;
  assign done_o         = done_q;
  assign alarm_o        = alarm_q;
  assign state_o        = state_q;
  assign msb_end_o      = msb_end_q;
  assign lsb_end_o      = lsb_end_q;
  assign msb_loadval_o  = 8'd0;
  assign lsb_loadval_o  = 8'd0;
  assign msb_resetval_o = 8'd0;
  assign lsb_resetval_o = 8'd0;

endmodule

// File: tb/tb_timer_mode_controller.sv
// Bench for timer_mode_controller: a behavioural datapath, a cycle reference model,
// an end-value vector table and directed multi-cycle sequences.

module tb_timer_mode_controller;

  localparam int LSB_MAX      = 99;
  localparam int MSB_MAX      = 99;
  localparam int ALARM_CYCLES = 200;
  localparam int SYNC_STAGES  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode = 1'b0;
  logic       start_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic [7:0] preset_msb = 8'd0;
  logic [7:0] preset_lsb = 8'd0;
  logic [7:0] dp_msb, dp_lsb;
  logic       start_stop, core_rst_n, lsb_overflow, done, alarm;
  logic [7:0] msb_loadval, lsb_loadval, msb_resetval, lsb_resetval, msb_end, lsb_end;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  timer_mode_controller #(
    .LSB_MAX(LSB_MAX), .MSB_MAX(MSB_MAX), .ALARM_CYCLES(ALARM_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .start_btn_i(start_btn), .clear_btn_i(clear_btn),
    .preset_msb_i(preset_msb), .preset_lsb_i(preset_lsb), .msb_val_i(dp_msb), .lsb_val_i(dp_lsb),
    .start_stop_o(start_stop), .core_rst_n_o(core_rst_n),
    .msb_loadval_o(msb_loadval), .lsb_loadval_o(lsb_loadval),
    .msb_resetval_o(msb_resetval), .lsb_resetval_o(lsb_resetval),
    .msb_end_o(msb_end), .lsb_end_o(lsb_end), .lsb_overflow_o(lsb_overflow),
    .done_o(done), .alarm_o(alarm), .state_o(state)
  );

  always #5 clk = ~clk;

  // Datapath: LSB/MSB up-counter pair that holds at its end value
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_msb <= 8'd0; dp_lsb <= 8'd0;
    end else if (!core_rst_n) begin
      dp_msb <= 8'd0; dp_lsb <= 8'd0;
    end else if (start_stop && !(dp_msb == msb_end && dp_lsb == lsb_end)) begin
      if (lsb_overflow) begin
        dp_lsb <= 8'd0; dp_msb <= dp_msb + 8'd1;
      end else begin
        dp_lsb <= dp_lsb + 8'd1;
      end
    end
  end

  // Reference model: phases 0 idle,1 run,2 pause,3 done; counts as single totals
  bit [SYNC_STAGES:0] hs, hc;
  int         m_phase, m_alarm_left, m_cur, m_endt;
  bit         m_ss, m_crn, m_sp, m_cp, alarm_exp, ovf_exp;
  logic [7:0] m_end_m, m_end_l;

  assign m_sp      = hs[SYNC_STAGES-1] & ~hs[SYNC_STAGES];
  assign m_cp      = hc[SYNC_STAGES-1] & ~hc[SYNC_STAGES];
  assign m_cur     = int'(dp_msb) * (LSB_MAX + 1) + int'(dp_lsb);
  assign m_endt    = int'(m_end_m) * (LSB_MAX + 1) + int'(m_end_l);
  assign alarm_exp = (m_phase == 3) && (m_alarm_left > 0);
  assign ovf_exp   = m_ss && (int'(dp_lsb) == LSB_MAX) && (m_cur != m_endt);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hs <= '0; hc <= '0; m_phase <= 0; m_ss <= 1'b0; m_crn <= 1'b0; m_alarm_left <= 0;
      m_end_m <= 8'(MSB_MAX); m_end_l <= 8'(LSB_MAX);
    end else begin
      hs    <= {hs[SYNC_STAGES-1:0], start_btn};
      hc    <= {hc[SYNC_STAGES-1:0], clear_btn};
      m_crn <= !m_cp;
      if (m_phase == 0) begin
        m_end_m <= mode ? preset_msb : 8'(MSB_MAX);
        m_end_l <= !mode ? 8'(LSB_MAX) : ((int'(preset_lsb) > LSB_MAX) ? 8'(LSB_MAX) : preset_lsb);
      end
      if (m_cp) begin
        m_phase <= 0; m_ss <= 1'b0; m_alarm_left <= 0;
      end else if (m_phase == 0 && m_sp) begin
        if (m_endt == 0) begin m_phase <= 3; m_alarm_left <= ALARM_CYCLES; end
        else begin m_phase <= 1; m_ss <= 1'b1; end
      end else if (m_phase == 1 && m_cur == m_endt) begin
        m_phase <= 3; m_ss <= 1'b0; m_alarm_left <= ALARM_CYCLES;
      end else if (m_phase == 1 && m_sp) begin
        m_phase <= 2; m_ss <= 1'b0;
      end else if (m_phase == 2 && m_sp) begin
        m_phase <= 1; m_ss <= 1'b1;
      end else if (m_phase == 3 && m_alarm_left > 0) begin
        m_alarm_left <= m_alarm_left - 1;
      end
    end
  end

  logic [55:0] exp_vec, act_vec;
  assign exp_vec = {3'(m_phase), m_ss, m_crn, (m_phase == 3), alarm_exp, m_end_m, m_end_l, ovf_exp, 32'd0};
  assign act_vec = {state, start_stop, core_rst_n, done, alarm, msb_end, lsb_end, lsb_overflow,
                    msb_loadval, lsb_loadval, msb_resetval, lsb_resetval};

  // Every cycle: all outputs against the reference model
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec <= n_vec + 1;
      if (act_vec !== exp_vec) begin
        n_err <= n_err + 1;
        $display("FAIL model t=%0t got %h expected %h (state,ss,crn,done,alarm,mend,lend,ovf,consts)",
                 $time, act_vec, exp_vec);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_start();
    start_btn = 1'b1; @(negedge clk); start_btn = 1'b0;
  endtask

  task automatic press_clear();
    clear_btn = 1'b1; @(negedge clk); clear_btn = 1'b0; tick(5);
  endtask

  task automatic wait_count(input int m, input int l, input int bound, input string name);
    int k = 0;
    while (!(int'(dp_msb) == m && int'(dp_lsb) == l) && k < bound) begin
      @(negedge clk); k++;
    end
    check(name, int'(dp_msb) * 100 + int'(dp_lsb), m * 100 + l);
  endtask

  task automatic wait_done(input int bound, input string name);
    int k = 0;
    while (!done && k < bound) begin
      @(negedge clk); k++;
    end
    check(name, int'(done), 1);
  endtask

  typedef struct {
    logic       md;
    logic [7:0] pm, pl, em, el;
  } end_vec_t;
  end_vec_t tv[8];

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bit ss_seen;
    tv[0] = '{1'b0, 8'd5,   8'd7,   8'd99,  8'd99};
    tv[1] = '{1'b1, 8'd0,   8'd5,   8'd0,   8'd5};
    tv[2] = '{1'b1, 8'd12,  8'd99,  8'd12,  8'd99};
    tv[3] = '{1'b1, 8'd3,   8'd100, 8'd3,   8'd99};
    tv[4] = '{1'b1, 8'd0,   8'd150, 8'd0,   8'd99};
    tv[5] = '{1'b1, 8'd255, 8'd255, 8'd255, 8'd99};
    tv[6] = '{1'b1, 8'd7,   8'd0,   8'd7,   8'd0};
    tv[7] = '{1'b0, 8'd0,   8'd0,   8'd99,  8'd99};

    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    check("reset state", int'(state), 0);
    check("reset start_stop", int'(start_stop), 0);
    check("reset core_rst_n", int'(core_rst_n), 0);
    check("reset done/alarm", int'({done, alarm}), 0);
    check("reset ends", int'({msb_end, lsb_end}), (99 << 8) | 99);
    tick(2);
    rst = 1'b0;
    tick(2);

    // End-value table, applied while idle
    for (int i = 0; i < 8; i++) begin
      mode = tv[i].md; preset_msb = tv[i].pm; preset_lsb = tv[i].pl;
      @(negedge clk);
      check("table msb_end", int'(msb_end), int'(tv[i].em));
      check("table lsb_end", int'(lsb_end), int'(tv[i].el));
    end

    // Preset 00:00 goes straight to DONE with no run enable
    mode = 1'b1; preset_msb = 8'd0; preset_lsb = 8'd0;
    tick(2);
    press_start();
    ss_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); ss_seen = ss_seen | start_stop;
    end
    check("zero preset start_stop", int'(ss_seen), 0);
    check("zero preset state", int'(state), 3);
    press_clear();

    // Timer to 00:05: 3-edge latency, done at 00:05, 200-cycle alarm
    preset_lsb = 8'd5;
    tick(2);
    start_btn = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("latency edge2", int'(start_stop), 0);
    @(posedge clk);
    #1 check("latency edge3", int'(start_stop), 1);
    start_btn = 1'b0;
    @(negedge clk);
    wait_done(40, "timer done");
    check("timer final count", int'(dp_lsb), 5);
    check("timer stop", int'(start_stop), 0);
    k = 0;
    while (alarm && k < 400) begin
      k++; @(negedge clk);
    end
    check("alarm length", k, ALARM_CYCLES);
    press_clear();

    // Stopwatch: overflow at 00:99, stop at 99:99 without wrapping
    mode = 1'b0;
    tick(2);
    press_start();
    wait_count(0, 99, 200, "reach 00:99");
    check("overflow at 00:99", int'(lsb_overflow), 1);
    @(negedge clk);
    check("after overflow", int'(dp_msb) * 100 + int'(dp_lsb), 100);
    check("overflow single", int'(lsb_overflow), 0);
    wait_done(10200, "stopwatch done");
    check("stopwatch end", int'(dp_msb) * 100 + int'(dp_lsb), 9999);
    tick(3);
    check("no wrap", int'(dp_msb) * 100 + int'(dp_lsb), 9999);
    press_clear();

    // Pause at 00:20 for 50+ cycles, then resume without reload
    tick(2);
    press_start();
    wait_count(0, 17, 100, "reach 00:17");
    start_btn = 1'b1;
    tick(50);
    start_btn = 1'b0;
    check("paused state", int'(state), 2);
    check("paused count", int'(dp_lsb), 20);
    tick(5);
    check("still held", int'(dp_msb) * 100 + int'(dp_lsb), 20);
    press_start();
    k = 0;
    while (!start_stop && k < 10) begin
      @(negedge clk); k++;
    end
    check("resume count", int'(dp_lsb), 20);
    @(negedge clk);
    check("resume next", int'(dp_msb) * 100 + int'(dp_lsb), 21);

    // Mode change while running is ignored; clear beats a simultaneous start
    tick(5);
    mode = 1'b1; preset_msb = 8'd0; preset_lsb = 8'd5;
    tick(3);
    check("ends frozen", int'({msb_end, lsb_end}), (99 << 8) | 99);
    clear_btn = 1'b1; start_btn = 1'b1;
    @(negedge clk);
    clear_btn = 1'b0; start_btn = 1'b0;
    tick(2);
    check("clear+start state", int'(state), 0);
    check("clear pulse low", int'(core_rst_n), 0);
    @(negedge clk);
    check("clear pulse width", int'(core_rst_n), 1);
    check("no pause entry", int'(state), 0);

    // Asynchronous reset mid-run at 03:45
    mode = 1'b0;
    tick(3);
    press_start();
    wait_count(3, 45, 500, "reach 03:45");
    #2 rst = 1'b1;
    #1;
    check("async rst state", int'(state), 0);
    check("async rst ss", int'(start_stop), 0);
    check("async rst crn", int'(core_rst_n), 0);
    check("async rst done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("count after rst", int'(dp_msb) * 100 + int'(dp_lsb), 0);

    // Random buttons, modes and presets against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15, 0) == 0) start_btn = ~start_btn;
      clear_btn = ($urandom_range(249, 0) == 0);
      if ($urandom_range(99, 0) == 0) begin
        mode       = 1'($urandom_range(1, 0));
        preset_msb = 8'($urandom_range(2, 0));
        preset_lsb = 8'($urandom_range(255, 0));
      end
      if (i == 1500) begin
        #2 rst = 1'b1;
        #4 rst = 1'b0;
      end
      @(negedge clk);
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
